popcount_accum: RTL and testbench
=================================

# popcount_accum

Parametrised, pipelined population-count adder tree with per-frame accumulation for the acquire engine. Each valid beat counts the ones in a wide 1-bit correlation vector through a registered two-level tree. The count can optionally be mapped to a signed ±1 correlation value. A multi-beat sum is then accumulated between first/last markers and emitted as one result per frame, with saturation and an overflow flag.

## Interface
- IN_WIDTH, 1023: number of 1-bit inputs per beat (≥2).
- GROUP, 31: inputs per first-level group adder; last group zero-padded when IN_WIDTH is not a multiple.
- ACC_WIDTH, 16: signed accumulator/output width; must be ≥ CNT_W+1, where CNT_W = clog2(IN_WIDTH+1).
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush of pipeline valids, accumulator and overflow
- in_valid  in  1  beat qualifier
- in_data  in  IN_WIDTH  1-bit correlation inputs
- in_first  in  1  beat starts a new frame (sampled only with in_valid)
- in_last  in  1  beat ends the frame (sampled only with in_valid)
- signed_mode  in  1  0: value = count; 1: value = 2·count − IN_WIDTH (sampled with in_valid)
- out_valid  out  1  one-cycle result strobe
- out_sum  out  ACC_WIDTH  signed frame sum, two's complement
- out_overflow  out  1  frame saturated at least once, qualified by out_valid

## Operation
- Stage 1 (S1): NG = ceil(IN_WIDTH/GROUP) group popcounts, each clog2(GROUP+1) bits wide and registered. in_valid, in_first, in_last and signed_mode are registered alongside.
- Stage 2 (S2): sum of the NG groups into a CNT_W-bit registered count. Zero-extend before adding; the count never wraps.
- Stage 3 (S3): value computed and applied to the accumulator.
  - value = count (zero-extended) or 2·count − IN_WIDTH, sign-extended to ACC_WIDTH.
  - First beat (first=1): acc ← value; ovf ← 0.
  - Otherwise: acc ← sat(acc + value); ovf ← ovf | saturated.
  - sat clamps to +2^(ACC_WIDTH−1)−1 or −2^(ACC_WIDTH−1).
- Emission:
  - A beat with last=1 drives out_valid=1, out_sum = the post-update acc and out_overflow = the post-update ovf.
  - After emission the accumulator returns to 0 and ovf to 0.
- A beat with first=1 and last=1 is a single-beat frame.
- A beat without first after a last (or after reset/clear) accumulates onto 0.
- A first arriving mid-frame discards the partial sum and does not emit it.
- signed_mode is applied per beat; mixing modes within a frame is legal and is not checked.
- in_data is ignored when in_valid=0. Pipeline registers may hold stale data, but valid bits are 0.
- No backpressure: one beat per cycle accepted unconditionally.

## Timing
- Latency: beat at cycle t (in_valid=1, in_last=1) → out_valid=1 at t+3.
- Throughput: one beat per cycle. Back-to-back frames are allowed; a last at t followed by a first at t+1 gives results at t+3 and t+4.
- out_valid is high for exactly one cycle per last beat. out_sum and out_overflow hold their values until the next emission.
- Reset values: out_valid=0, out_sum=0, out_overflow=0. All pipeline valids, the accumulator and ovf are 0.
- Reset mid-frame: all in-flight beats are lost; no output is emitted for them.
- clear at cycle c:
  - Beats registered at or before c never reach S3.
  - out_valid=0 at c+1. The accumulator is 0 and ovf is 0 at c+1.
  - A beat presented in the same cycle c is also discarded.
  - out_sum/out_overflow are not changed by clear.
- Saturation is detected in S3 per add. The clamped value persists, and later adds of the opposite sign move away from the rail normally.

## Test plan
- Single beat, all ones, defaults, unsigned, first=last=1 at t → out_valid at t+3, out_sum=1023, out_overflow=0. All zeros in signed mode → −1023.
- IN_WIDTH=1000, GROUP=31 (padded group): bits 0..499 set, unsigned → 500. Signed mode → 0.
- Four-beat frame, each beat with 341 ones, signed_mode=1 (value −341 each) → single out_valid 3 cycles after the last beat, out_sum=−1364. No out_valid on the intermediate beats.
- ACC_WIDTH=12, unsigned, three beats of 1023 → clamped at 2047, out_overflow=1. The next frame of one beat with 5 ones → out_sum=5, out_overflow=0.
- Back-to-back frames every cycle (first=last=1, counts 1,2,3…) → out_valid high continuously from t+3 with sums 1,2,3… in order.
- clear asserted one cycle after a mid-frame beat → no emission for that frame; a following beat without first, last=1, 7 ones → out_sum=7. rst pulse mid-frame → all outputs 0, no spurious out_valid.

Source files
------------

// File: rtl/popcount_accum_if.sv
// -----------------------------------------------------------------------------
// popcount_accum_if
//   Beat/result bundle for popcount_accum. The producer of correlation beats
//   (master) drives the beat fields and clear; the accumulator (slave) drives
//   the per-frame result fields.
//
//   clear        synchronous flush of pipeline valids, accumulator and overflow
//   in_valid     beat qualifier
//   in_data      IN_WIDTH 1-bit correlation inputs
//   in_first     beat starts a new frame
//   in_last      beat ends the frame
//   signed_mode  0: value = count, 1: value = 2*count - IN_WIDTH
//   out_valid    one-cycle result strobe
//   out_sum      signed frame sum (ACC_WIDTH bits)
//   out_overflow frame saturated at least once
// -----------------------------------------------------------------------------
interface popcount_accum_if #(
    parameter int IN_WIDTH  = 1023,
    parameter int ACC_WIDTH = 16
);
    logic                        clear;
    logic                        in_valid;
    logic [IN_WIDTH-1:0]         in_data;
    logic                        in_first;
    logic                        in_last;
    logic                        signed_mode;
    logic                        out_valid;
    logic signed [ACC_WIDTH-1:0] out_sum;
    logic                        out_overflow;

    modport master (
        output clear, in_valid, in_data, in_first, in_last, signed_mode,
        input  out_valid, out_sum, out_overflow
    );

    modport slave (
        input  clear, in_valid, in_data, in_first, in_last, signed_mode,
        output out_valid, out_sum, out_overflow
    );
endinterface

// File: rtl/popcount_accum.sv
// -----------------------------------------------------------------------------
// popcount_accum
//   Three-stage population count with per-frame accumulation.
//     S1: popcount of each GROUP-bit slice of in_data (last slice zero-padded)
//     S2: sum of the group counts into a CNT_W-bit count
//     S3: count (or 2*count - IN_WIDTH) added into a saturating accumulator;
//         a last beat publishes the frame sum and overflow flag.
//   Latency from an accepted last beat to out_valid is three cycles.
//
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  popcount_accum_if slave port (beat inputs, clear, frame result)
// -----------------------------------------------------------------------------
module popcount_accum #(
    parameter int IN_WIDTH  = 1023,
    parameter int GROUP     = 31,
    parameter int ACC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    popcount_accum_if.slave  bus
);
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int NG    = (IN_WIDTH + GROUP - 1) / GROUP;
    localparam int GW    = $clog2(GROUP + 1);
    localparam int PAD_W = NG * GROUP;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Control flops (reset)
    logic                 s1_valid_q, s1_valid_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic                 out_ovf_q, out_ovf_d;

    // Data-path flops (qualified by the valid bits above)
    logic [GW-1:0]        grp_q [NG];
    logic [GW-1:0]        grp_d [NG];
    logic                 s1_first_q, s1_first_d;
    logic                 s1_last_q, s1_last_d;
    logic                 s1_signed_q, s1_signed_d;
    logic [CNT_W-1:0]     s2_cnt_q, s2_cnt_d;
    logic                 s2_first_q, s2_first_d;
    logic                 s2_last_q, s2_last_d;
    logic                 s2_signed_q, s2_signed_d;

    // S3 intermediates
    logic [PAD_W-1:0]     padded;
    logic [ACC_WIDTH-1:0] value;
    logic [ACC_WIDTH-1:0] base;
    logic                 ovf_base;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 sat;
    logic [ACC_WIDTH-1:0] sum_sat;

    // S1: group popcounts
    always_comb begin
        // NOTE: every variable gets a default before any conditional or loop
        // update, so no path leaves it unassigned and no latch is inferred.
        padded = '0;
        padded[IN_WIDTH-1:0] = bus.in_data;
        for (int g = 0; g < NG; g++) begin
            grp_d[g] = '0;
            for (int b = 0; b < GROUP; b++) begin
                grp_d[g] = grp_d[g] + GW'(padded[g*GROUP + b]);
            end
        end
        // A beat presented together with clear is dropped.
        s1_valid_d  = bus.in_valid & ~bus.clear;
        s1_first_d  = bus.in_first;
        s1_last_d   = bus.in_last;
        s1_signed_d = bus.signed_mode;
    end

    // S2: total count, S3: accumulate and emit
    always_comb begin
        s2_cnt_d = '0;
        for (int g = 0; g < NG; g++) begin
            s2_cnt_d = s2_cnt_d + CNT_W'(grp_q[g]);
        end
        s2_valid_d  = s1_valid_q & ~bus.clear;
        s2_first_d  = s1_first_q;
        s2_last_d   = s1_last_q;
        s2_signed_d = s1_signed_q;

        // ACC_WIDTH >= CNT_W+1 keeps 2*count in range before subtracting.
        if (s2_signed_q) begin
            value = ACC_WIDTH'({s2_cnt_q, 1'b0}) - ACC_WIDTH'(IN_WIDTH);
        end else begin
            value = ACC_WIDTH'(s2_cnt_q);
        end

        base     = s2_first_q ? '0   : acc_q;
        ovf_base = s2_first_q ? 1'b0 : ovf_q;

        // One guard bit: a sign mismatch between the top two bits is overflow,
        // and the guard bit tells which rail to clamp to.
        sum_wide = {base[ACC_WIDTH-1], base} + {value[ACC_WIDTH-1], value};
        sat      = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        if (!sat) begin
            sum_sat = sum_wide[ACC_WIDTH-1:0];
        end else if (sum_wide[ACC_WIDTH]) begin
            sum_sat = ACC_MIN;
        end else begin
            sum_sat = ACC_MAX;
        end

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (bus.clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (s2_valid_q) begin
            if (s2_last_q) begin
                out_valid_d = 1'b1;
                out_sum_d   = sum_sat;
                out_ovf_d   = ovf_base | sat;
                acc_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = sum_sat;
                ovf_d = ovf_base | sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments make every flop sample the values
        // from before the edge, independent of statement order.
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // NOTE: the wide data-path registers are not reset; their contents are
    // never used unless the matching valid bit (which is reset) is set.
    always_ff @(posedge clk) begin
        grp_q       <= grp_d;
        s1_first_q  <= s1_first_d;
        s1_last_q   <= s1_last_d;
        s1_signed_q <= s1_signed_d;
        s2_cnt_q    <= s2_cnt_d;
        s2_first_q  <= s2_first_d;
        s2_last_q   <= s2_last_d;
        s2_signed_q <= s2_signed_d;
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_overflow = out_ovf_q;
endmodule

// File: tb/tb_popcount_accum.sv
// -----------------------------------------------------------------------------
// tb_popcount_accum
//   Two instances: dut_a with default parameters (1023 inputs, 16-bit acc)
//   and dut_b with 1000 inputs (padded last group) and a 12-bit accumulator.
//   A table of beats is streamed one per cycle; each record's result is
//   compared three cycles after it was presented. Clear and reset corner
//   cases follow as hand-written sequences on dut_a.
// -----------------------------------------------------------------------------
module tb_popcount_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    popcount_accum_if #(.IN_WIDTH(1023), .ACC_WIDTH(16)) bus_a ();
    popcount_accum_if #(.IN_WIDTH(1000), .ACC_WIDTH(12)) bus_b ();

    popcount_accum #(.IN_WIDTH(1023), .GROUP(31), .ACC_WIDTH(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    popcount_accum #(.IN_WIDTH(1000), .GROUP(31), .ACC_WIDTH(12)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        bit b;     // 0: dut_a, 1: dut_b
        bit v, f, l, s;
        int n;     // number of ones in the low bits of in_data
        bit ev;    // expected out_valid
        int esum;
        bit eovf;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1022:0] ones(input int n);
        logic [1022:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit v, input bit f, input bit l, input bit s, input int n);
        bus_a.in_valid    = v;
        bus_a.in_first    = f;
        bus_a.in_last     = l;
        bus_a.signed_mode = s;
        bus_a.in_data     = ones(n);
    endtask

    task automatic drive_b(input bit v, input bit f, input bit l, input bit s, input int n);
        logic [1022:0] t;
        t = ones(n);
        bus_b.in_valid    = v;
        bus_b.in_first    = f;
        bus_b.in_last     = l;
        bus_b.signed_mode = s;
        bus_b.in_data     = t[999:0];
    endtask

    task automatic add(input bit b, input bit v, input bit f, input bit l, input bit s,
                       input int n, input bit ev, input int esum, input bit eovf);
        vec_t r;
        r = '{b, v, f, l, s, n, ev, esum, eovf};
        tbl.push_back(r);
    endtask

    task automatic apply(input vec_t r);
        if (r.b) begin
            drive_a(0, 0, 0, 0, 0);
            drive_b(r.v, r.f, r.l, r.s, r.n);
        end else begin
            drive_a(r.v, r.f, r.l, r.s, r.n);
            drive_b(0, 0, 0, 0, 0);
        end
    endtask

    task automatic check_rec(input int idx, input vec_t r);
        int av, as, ao;
        if (r.b) begin
            av = int'(bus_b.out_valid);
            as = int'(bus_b.out_sum);
            ao = int'(bus_b.out_overflow);
        end else begin
            av = int'(bus_a.out_valid);
            as = int'(bus_a.out_sum);
            ao = int'(bus_a.out_overflow);
        end
        check($sformatf("rec%0d_valid", idx), av, int'(r.ev));
        if (r.ev) begin
            check($sformatf("rec%0d_sum", idx), as, r.esum);
            check($sformatf("rec%0d_ovf", idx), ao, int'(r.eovf));
        end
    endtask

    task automatic expect_a(input string name, input bit v, input int sum, input bit ovf);
        check({name, "_valid"}, int'(bus_a.out_valid), int'(v));
        check({name, "_sum"}, int'(bus_a.out_sum), sum);
        check({name, "_ovf"}, int'(bus_a.out_overflow), int'(ovf));
    endtask

    initial begin
        //   b  v  f  l  s  ones  ev  sum    ovf
        add(0, 1, 1, 1, 0, 1023, 1,  1023,  0);  // all ones, unsigned
        add(0, 1, 1, 1, 1, 0,    1, -1023,  0);  // all zeros, signed
        add(0, 1, 1, 0, 1, 341,  0,  0,     0);  // four-beat signed frame
        add(0, 1, 0, 0, 1, 341,  0,  0,     0);
        add(0, 1, 0, 0, 1, 341,  0,  0,     0);
        add(0, 1, 0, 1, 1, 341,  1, -1364,  0);
        add(0, 1, 1, 1, 0, 1,    1,  1,     0);  // back-to-back frames
        add(0, 1, 1, 1, 0, 2,    1,  2,     0);
        add(0, 1, 1, 1, 0, 3,    1,  3,     0);
        add(0, 1, 0, 1, 0, 7,    1,  7,     0);  // no first after last: onto 0
        add(0, 1, 1, 0, 0, 100,  0,  0,     0);  // partial frame ...
        add(0, 1, 1, 0, 0, 20,   0,  0,     0);  // ... discarded by new first
        add(0, 1, 0, 1, 0, 5,    1,  25,    0);
        add(0, 1, 1, 1, 1, 512,  1,  1,     0);  // signed 2*512-1023
        add(0, 1, 1, 0, 0, 10,   0,  0,     0);  // mixed modes in one frame
        add(0, 1, 0, 1, 1, 0,    1, -1013,  0);
        add(0, 0, 1, 1, 0, 1023, 0,  0,     0);  // invalid beat ignored
        add(0, 1, 1, 1, 0, 1023, 1,  1023,  0);
        add(1, 1, 1, 1, 0, 500,  1,  500,   0);  // padded group, unsigned
        add(1, 1, 1, 1, 1, 500,  1,  0,     0);  // padded group, signed
        add(1, 1, 1, 0, 0, 1000, 0,  0,     0);  // positive saturation
        add(1, 1, 0, 0, 0, 1000, 0,  0,     0);
        add(1, 1, 0, 1, 0, 1000, 1,  2047,  1);
        add(1, 1, 1, 1, 0, 5,    1,  5,     0);  // overflow cleared next frame
        add(1, 1, 1, 0, 1, 0,    0,  0,     0);  // negative saturation
        add(1, 1, 0, 0, 1, 0,    0,  0,     0);
        add(1, 1, 0, 1, 1, 0,    1, -2048,  1);
        add(1, 1, 1, 0, 0, 1000, 0,  0,     0);  // clamp, then move off the rail
        add(1, 1, 0, 0, 0, 1000, 0,  0,     0);
        add(1, 1, 0, 0, 0, 1000, 0,  0,     0);
        add(1, 1, 0, 1, 1, 0,    1,  1047,  1);
        add(1, 1, 1, 1, 1, 1000, 1,  1000,  0);

        bus_a.clear = 1'b0;
        bus_b.clear = 1'b0;
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        step();
        step();
        expect_a("reset_a", 0, 0, 0);
        check("reset_b_valid", int'(bus_b.out_valid), 0);
        check("reset_b_sum", int'(bus_b.out_sum), 0);
        check("reset_b_ovf", int'(bus_b.out_overflow), 0);
        rst = 1'b0;
        step();

        // A beat driven in cycle c shows its result in cycle c+3, i.e. two
        // steps after the step that follows driving it.
        for (int c = 0; c < tbl.size() + 2; c++) begin
            if (c < tbl.size()) apply(tbl[c]);
            else begin
                drive_a(0, 0, 0, 0, 0);
                drive_b(0, 0, 0, 0, 0);
            end
            step();
            if (c >= 2) check_rec(c - 2, tbl[c - 2]);
        end

        // clear one cycle after a mid-frame beat, with a complete beat
        // presented in the clear cycle itself: neither may emit.
        drive_a(1, 1, 0, 0, 50);
        step();
        bus_a.clear = 1'b1;
        drive_a(1, 1, 1, 0, 9);
        step();
        bus_a.clear = 1'b0;
        drive_a(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clear_quiet%0d", i), int'(bus_a.out_valid), 0);
            step();
        end
        check("clear_sum_hold", int'(bus_a.out_sum), 1023);
        drive_a(1, 0, 1, 0, 7);
        step();
        drive_a(0, 0, 0, 0, 0);
        step();
        step();
        expect_a("after_clear", 1, 7, 0);
        step();
        check("strobe_one_cycle", int'(bus_a.out_valid), 0);

        // Reset with two beats of a frame in flight.
        drive_a(1, 1, 0, 0, 30);
        step();
        drive_a(1, 0, 1, 0, 40);
        step();
        drive_a(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 expect_a("mid_reset", 0, 0, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_quiet%0d", i), int'(bus_a.out_valid), 0);
            step();
        end
        drive_a(1, 0, 1, 0, 3);
        step();
        drive_a(0, 0, 0, 0, 0);
        step();
        step();
        expect_a("after_reset", 1, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
